comparator_serial: RTL

- Parametrised successor to the single-bit comparator.
- Compares two WIDTH-bit operands bit-serially, MSB first, one bit per clock, with a start/done handshake.
- Supports unsigned and two's-complement signed comparison, selected per operation.
- Terminates early at the first differing bit.
- Serves as a low-area magnitude comparator for control paths where latency is acceptable.

---
 rtl/comparator_pkg.sv | 16 +
 rtl/comparator_1bit.sv | 14 +
 rtl/comparator_serial.sv | 111 +++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    // An index register needs at least one bit, even when WIDTH is 1 or 2.
    function automatic int idx_width(input int w);
        int cw;
        cw = $clog2(w);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/comparator_1bit.sv
// Single-bit magnitude comparator used for the per-bit decision.
module comparator_1bit (
    input  logic a,
    input  logic b,
    output logic smaller,
    output logic greater,
    output logic equal
);

    assign smaller = ~a & b;
    assign greater = a & ~b;
    assign equal   = ~(a ^ b);

endmodule

// File: rtl/comparator_serial.sv
// MSB-first bit-serial comparator with start/done handshake and optional
// two's-complement interpretation; stops at the first differing bit.
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             smaller,
    output logic             greater,
    output logic             equal
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic             done_q;
    logic             smaller_q;
    logic             greater_q;
    logic             equal_q;

    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic             bit_lt_d;
    logic             bit_gt_d;
    logic             bit_eq_d;
    logic             swap_d;
    logic             smaller_d;
    logic             greater_d;

    // Shifting instead of indexing keeps the select legal for every WIDTH.
    assign a_sh_d = a_q >> idx_q;
    assign b_sh_d = b_q >> idx_q;

    comparator_1bit u_bit (
        .a       (a_sh_d[0]),
        .b       (b_sh_d[0]),
        .smaller (bit_lt_d),
        .greater (bit_gt_d),
        .equal   (bit_eq_d)
    );

    // On the sign bit a 1 means negative, so the unsigned sense flips.
    assign swap_d    = signed_q && (idx_q == MSB_IDX);
    assign smaller_d = swap_d ? bit_gt_d : bit_lt_d;
    assign greater_d = swap_d ? bit_lt_d : bit_gt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            done_q    <= 1'b0;
            smaller_q <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        signed_q <= is_signed;
                        idx_q    <= MSB_IDX;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    if (!bit_eq_d) begin
                        smaller_q <= smaller_d;
                        greater_q <= greater_d;
                        equal_q   <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else if (idx_q == '0) begin
                        smaller_q <= 1'b0;
                        greater_q <= 1'b0;
                        equal_q   <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q == CMP);
    assign done    = done_q;
    assign smaller = smaller_q;
    assign greater = greater_q;
    assign equal   = equal_q;

endmodule
